// File: rtl/nvdla_dbb_tcdm_writer.sv
// Write-side adapter from the NVDLA DBB output stream to the cluster TCDM.
// Each stream beat is split into chunks of MP parallel 32-bit word writes at consecutive addresses.
module nvdla_dbb_tcdm_writer #(
  parameter int DATA_W = 256,
  parameter int MP     = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [CNT_W-1:0]    n_beats_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [MP-1:0]       tcdm_req_o,
  input  logic [MP-1:0]       tcdm_gnt_i,
  output logic [MP*32-1:0]    tcdm_add_o,
  output logic [MP-1:0]       tcdm_wen_o,
  output logic [MP*4-1:0]     tcdm_be_o,
  output logic [MP*32-1:0]    tcdm_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    beats_done_o
);

  localparam int                N_CHUNK     = DATA_W / (32 * MP);
  localparam int                CHUNK_W     = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);
  localparam logic [31:0]       CHUNK_BYTES = 32'(4 * MP);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE,
    DONE
  } state_t;

  state_t              state_q;
  logic [31:0]         addr_q;
  logic [CNT_W-1:0]    beats_left_q;
  logic [CNT_W-1:0]    beats_done_q;
  logic [DATA_W-1:0]   beat_q;
  logic [CHUNK_W-1:0]  chunk_idx_q;
  logic [MP-1:0]       lane_done_q;
  logic                chunk_done;

  // A lane granted this cycle counts as done, so the chunk can retire in the same cycle.
  assign chunk_done = (state_q == ISSUE) && ((lane_done_q | tcdm_gnt_i) == '1);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      beats_done_q <= '0;
      // NOTE: the beat register is a plain datapath register, not a memory array,
      // so clearing it on reset is cheap and keeps the lane data outputs defined.
      beat_q       <= '0;
      chunk_idx_q  <= '0;
      lane_done_q  <= '0;
    end else if (clear_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      beats_done_q <= '0;
      beat_q       <= '0;
      chunk_idx_q  <= '0;
      lane_done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            beats_done_q <= '0;
            if (n_beats_i != '0) begin
              addr_q       <= base_addr_i;
              beats_left_q <= n_beats_i;
              state_q      <= LOAD;
            end else begin
              state_q <= DONE;
            end
          end
        end
        LOAD: begin
          if (valid_i) begin
            beat_q      <= data_i;
            chunk_idx_q <= '0;
            lane_done_q <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (chunk_done) begin
            addr_q      <= addr_q + CHUNK_BYTES;
            lane_done_q <= '0;
            // Shifting keeps the active chunk in the low lanes of the beat register.
            beat_q      <= beat_q >> (32 * MP);
            if (chunk_idx_q != LAST_CHUNK) begin
              chunk_idx_q <= chunk_idx_q + 1'b1;
            end else begin
              beats_done_q <= beats_done_q + 1'b1;
              beats_left_q <= beats_left_q - 1'b1;
              state_q      <= (beats_left_q == CNT_W'(1)) ? DONE : LOAD;
            end
          end else begin
            lane_done_q <= lane_done_q | tcdm_gnt_i;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o      = (state_q == LOAD);
  assign busy_o       = (state_q == LOAD) || (state_q == ISSUE);
  assign done_o       = (state_q == DONE);
  assign beats_done_o = beats_done_q;
  assign tcdm_req_o   = (state_q == ISSUE) ? ~lane_done_q : '0;
  assign tcdm_wen_o   = '0;
  assign tcdm_be_o    = '1;

  for (genvar k = 0; k < MP; k++) begin : g_lane
    assign tcdm_add_o[k*32 +: 32]  = addr_q + 32'(4 * k);
    assign tcdm_data_o[k*32 +: 32] = beat_q[k*32 +: 32];
  end

endmodule

// File: tb/tb_nvdla_dbb_tcdm_writer.sv
// Self-checking bench for nvdla_dbb_tcdm_writer: table of transfers checked against an
// address->data write map, plus hand sequences for clear, clear+start and async reset.
module tb_nvdla_dbb_tcdm_writer;

  localparam int DATA_W = 256;
  localparam int MP     = 4;
  localparam int CNT_W  = 16;
  localparam int WPB    = DATA_W / 32;

  logic              clk_i = 1'b0;
  logic              rst_i, clear_i, start_i, valid_i;
  logic [31:0]       base_addr_i;
  logic [CNT_W-1:0]  n_beats_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o, busy_o, done_o;
  logic [MP-1:0]     tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
  logic [MP*32-1:0]  tcdm_add_o, tcdm_data_o;
  logic [MP*4-1:0]   tcdm_be_o;
  logic [CNT_W-1:0]  beats_done_o;

  always #5 clk_i = ~clk_i;

  nvdla_dbb_tcdm_writer #(.DATA_W(DATA_W), .MP(MP), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .n_beats_i(n_beats_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .tcdm_req_o(tcdm_req_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .busy_o(busy_o),
    .done_o(done_o), .beats_done_o(beats_done_o)
  );

  int checks;
  int failures;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int          n_beats;
    int          gnt_mode;      // 0: grants always high, 1: random per lane
    int          gap;           // cycles between offered beats
    int          stall_lane;
    int          stall_cycles;
    int          exp_words;
    int          exp_beats;
    int          exp_lat;       // cycles from start to done_o; 0 = not checked
  } vec_t;

  vec_t vecs[8];

  // Reference model: every word of every beat must land exactly once at base + 4*index.
  logic [31:0] exp_mem [logic [31:0]];
  bit          wr_seen [logic [31:0]];

  task automatic run_xfer(input vec_t v, input string tag);
    logic [DATA_W-1:0] beats[$];
    logic [DATA_W-1:0] bt;
    logic [MP-1:0]     prev_req, prev_gnt, gnt;
    logic [MP*32-1:0]  prev_add, prev_data;
    logic [CNT_W-1:0]  prev_bd;
    logic [31:0]       a, d;
    int acc, words, done_cnt, lat, post, cyc, cool, stall_left;
    bit any_req, any_ready;

    beats.delete(); exp_mem.delete(); wr_seen.delete();
    for (int b = 0; b < v.n_beats; b++) begin
      for (int w = 0; w < WPB; w++) bt[w*32 +: 32] = $urandom;
      beats.push_back(bt);
      for (int w = 0; w < WPB; w++) begin
        a = v.base + 32'(4 * (b * WPB + w));
        exp_mem[a] = bt[w*32 +: 32];
      end
    end
    acc = 0; words = 0; done_cnt = 0; lat = 0; post = 0; cool = 0;
    stall_left = v.stall_cycles; any_req = 0; any_ready = 0;

    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = v.base; n_beats_i = CNT_W'(v.n_beats);
    @(negedge clk_i);
    start_i = 1'b0; cyc = 1;
    check({tag, "_bd_cleared"}, beats_done_o, 0);
    prev_bd = '0; prev_req = '0; prev_gnt = '0; prev_add = '0; prev_data = '0;

    while (post < 3 && cyc < 3000) begin
      if (done_o) begin
        done_cnt++;
        if (lat == 0) lat = cyc;
        check({tag, "_busy_at_done"}, busy_o, 0);
        check({tag, "_words_at_done"}, words, v.exp_words);
      end
      for (int k = 0; k < MP; k++) begin
        if (prev_req[k] && !prev_gnt[k]) begin
          check($sformatf("%s_req_held_l%0d", tag, k), tcdm_req_o[k], 1);
          check($sformatf("%s_add_stable_l%0d", tag, k), tcdm_add_o[k*32 +: 32], prev_add[k*32 +: 32]);
          check($sformatf("%s_data_stable_l%0d", tag, k), tcdm_data_o[k*32 +: 32], prev_data[k*32 +: 32]);
        end
      end
      if (beats_done_o != prev_bd) check({tag, "_bd_step"}, beats_done_o, prev_bd + 1'b1);
      if (ready_o) any_ready = 1;
      if (tcdm_req_o != '0) any_req = 1;
      if (ready_o || tcdm_req_o != '0) check({tag, "_busy_active"}, busy_o, 1);

      for (int k = 0; k < MP; k++) gnt[k] = (v.gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_left > 0 && tcdm_req_o[v.stall_lane]) begin
        gnt[v.stall_lane] = 1'b0;
        stall_left--;
      end
      tcdm_gnt_i = gnt;

      if (acc < v.n_beats && cool == 0) begin
        valid_i = 1'b1;
        data_i  = beats[acc];
      end else begin
        valid_i = 1'b0;
      end

      for (int k = 0; k < MP; k++) begin
        if (tcdm_req_o[k] && gnt[k]) begin
          a = tcdm_add_o[k*32 +: 32];
          d = tcdm_data_o[k*32 +: 32];
          check($sformatf("%s_addr_expected_%08h", tag, a), exp_mem.exists(a), 1);
          if (exp_mem.exists(a)) begin
            check($sformatf("%s_data_%08h", tag, a), d, exp_mem[a]);
            check($sformatf("%s_once_%08h", tag, a), wr_seen.exists(a), 0);
            wr_seen[a] = 1;
            words++;
          end
        end
      end

      if (valid_i && ready_o) begin
        acc++;
        cool = v.gap - 1;
      end else if (cool > 0) begin
        cool--;
      end

      prev_req = tcdm_req_o; prev_gnt = gnt; prev_add = tcdm_add_o;
      prev_data = tcdm_data_o; prev_bd = beats_done_o;
      if (done_cnt > 0) post++;
      @(negedge clk_i);
      cyc++;
    end

    valid_i = 1'b0; tcdm_gnt_i = '0;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_words"}, words, v.exp_words);
    check({tag, "_beats_done"}, beats_done_o, v.exp_beats);
    check({tag, "_beats_taken"}, acc, v.n_beats);
    check({tag, "_ready_seen"}, any_ready, v.n_beats != 0);
    check({tag, "_req_seen"}, any_req, v.n_beats != 0);
    if (v.exp_lat != 0) check({tag, "_latency"}, lat, v.exp_lat);
  endtask

  task automatic clear_mid_transfer();
    int cyc, cnt;
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 32'h3000; n_beats_i = CNT_W'(4);
    valid_i = 1'b1; data_i = {8{$urandom}}; tcdm_gnt_i = '1;
    @(negedge clk_i);
    start_i = 1'b0; cyc = 0;
    while (!(beats_done_o == CNT_W'(1) && tcdm_req_o != '0) && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check("clr_reached_beat2", cyc < 100, 1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; valid_i = 1'b0;
    check("clr_req", tcdm_req_o, 0);
    check("clr_busy", busy_o, 0);
    check("clr_ready", ready_o, 0);
    check("clr_bd", beats_done_o, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o || busy_o || tcdm_req_o != '0) cnt++;
    end
    check("clr_quiet", cnt, 0);
  endtask

  task automatic clear_with_start();
    int cnt;
    @(negedge clk_i);
    start_i = 1'b1; clear_i = 1'b1; base_addr_i = 32'h6000; n_beats_i = CNT_W'(2);
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0;
    check("clrstart_busy", busy_o, 0);
    check("clrstart_done", done_o, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (busy_o || done_o || ready_o) cnt++;
    end
    check("clrstart_quiet", cnt, 0);
  endtask

  task automatic async_reset_mid();
    int cyc;
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 32'h7000; n_beats_i = CNT_W'(2);
    valid_i = 1'b1; data_i = {8{$urandom}}; tcdm_gnt_i = '0;
    @(negedge clk_i);
    start_i = 1'b0; cyc = 0;
    while (tcdm_req_o == '0 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    check("arst_reached_issue", cyc < 20, 1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_req", tcdm_req_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_ready", ready_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    check("arst_bd", beats_done_o, 0);
    check("arst_done", done_o, 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    base_addr_i = '0; n_beats_i = '0; data_i = '0; tcdm_gnt_i = '0;

    repeat (2) @(negedge clk_i);
    check("rst_ready", ready_o, 0);
    check("rst_req", tcdm_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_bd", beats_done_o, 0);
    check("const_wen", tcdm_wen_o, 0);
    check("const_be", tcdm_be_o, {MP{4'hF}});
    rst_i = 1'b0;

    // Beats offered while idle must not be taken.
    valid_i = 1'b1; data_i = {8{32'hDEAD_BEEF}};
    repeat (2) @(negedge clk_i);
    check("idle_ready", ready_o, 0);
    check("idle_busy", busy_o, 0);
    valid_i = 1'b0;

    vecs[0] = '{32'h0000_0100, 1, 0, 1, 0, 0,  8, 1,  4};
    vecs[1] = '{32'h0000_2000, 0, 0, 1, 0, 0,  0, 0,  1};
    vecs[2] = '{32'h0000_4000, 3, 1, 1, 2, 5, 24, 3,  0};
    vecs[3] = '{32'h0000_0800, 4, 0, 4, 0, 0, 32, 4,  0};
    vecs[4] = '{32'hFFFF_FFF0, 1, 0, 1, 0, 0,  8, 1,  4};
    vecs[5] = '{32'h1234_5670, 2, 0, 1, 0, 0, 16, 2,  7};
    vecs[6] = '{32'hFFFF_FFE0, 3, 1, 2, 1, 3, 24, 3,  0};
    vecs[7] = '{32'h0000_9000, 5, 0, 1, 0, 0, 40, 5, 16};

    for (int i = 0; i < 8; i++) run_xfer(vecs[i], $sformatf("v%0d", i));

    clear_mid_transfer();
    run_xfer('{32'h0000_5000, 2, 1, 1, 0, 0, 16, 2, 0}, "after_clear");
    clear_with_start();
    async_reset_mid();
    run_xfer('{32'h0000_A000, 1, 0, 1, 0, 0, 8, 1, 4}, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
